// File: rtl/word_block_packer.sv
// word_block_packer: packs NWORDS words of WSIZE bits into one block with valid/ready on both sides
// Partial-block flush is compiled only when WORD_BLOCK_PACKER_FLUSH_EN is defined
module word_block_packer #(
  parameter int WSIZE = 32,
  parameter int NWORDS = 4,
  parameter bit FIRST_MSB = 1'b1,
  localparam int BSIZE = WSIZE * NWORDS,
  localparam int CW = $clog2(NWORDS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WSIZE-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [BSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count
);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);
  logic [BSIZE-1:0] acc_q, acc_d, obuf_q, obuf_d, placed;
  logic [CW-1:0] idx_q, idx_d, ocount_q, ocount_d;
  logic ovalid_q, ovalid_d, out_free, last, in_fire, complete;
  assign last = idx_q == LAST;
  assign out_free = !ovalid_q || out_ready;
`ifdef WORD_BLOCK_PACKER_FLUSH_EN
  logic flush_pend_q, flush_pend_d, flush_go;
  assign flush_go = flush_pend_q && out_free;
  assign in_ready = !flush_pend_q && (!last || out_free);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign in_ready = !last || out_free;
`endif
  assign in_fire = in_valid && in_ready;
  assign complete = in_fire && last;
  assign placed = BSIZE'(in_data) << (FIRST_MSB ? (NWORDS - 1 - int'(idx_q)) * WSIZE : int'(idx_q) * WSIZE);
  always_comb begin
    acc_d = in_fire ? (acc_q | placed) : acc_q;
    idx_d = in_fire ? idx_q + CW'(1) : idx_q;
    obuf_d = obuf_q;
    ocount_d = ocount_q;
    ovalid_d = ovalid_q && !out_ready;
    if (complete) begin
      obuf_d = acc_d;
      ocount_d = CW'(NWORDS);
      ovalid_d = 1'b1;
      acc_d = '0;
      idx_d = '0;
    end
`ifdef WORD_BLOCK_PACKER_FLUSH_EN
    // idx_d is already zero after a completed block, so that flush is a no-op
    flush_pend_d = flush_pend_q || (flush && idx_d != '0);
    if (flush_go) begin
      obuf_d = acc_q;
      ocount_d = idx_q;
      ovalid_d = 1'b1;
      acc_d = '0;
      idx_d = '0;
      flush_pend_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      obuf_q <= '0;
      idx_q <= '0;
      ocount_q <= '0;
      ovalid_q <= 1'b0;
`ifdef WORD_BLOCK_PACKER_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      obuf_q <= obuf_d;
      idx_q <= idx_d;
      ocount_q <= ocount_d;
      ovalid_q <= ovalid_d;
`ifdef WORD_BLOCK_PACKER_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end
  assign out_data = obuf_q;
  assign out_valid = ovalid_q;
  assign out_count = ocount_q;
endmodule

// File: tb/tb_word_block_packer.sv
// tb_word_block_packer: scoreboard bench for a 32x4 MSB-first packer and an 8x2 LSB-first packer
module tb_word_block_packer;
  localparam int AW = 32, AN = 4, BW = 8, BN = 2;
  localparam int ACW = $clog2(AN + 1), BCW = $clog2(BN + 1);
  logic clock = 1'b0, reset = 1'b1;
  logic [AW-1:0] a_in_data = '0;
  logic a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b1;
  logic [AW*AN-1:0] a_out_data;
  logic [ACW-1:0] a_out_count;
  logic [BW-1:0] b_in_data = '0;
  logic b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b1;
  logic [BW*BN-1:0] b_out_data;
  logic [BCW-1:0] b_out_count;
  typedef struct { logic [127:0] data; int count; } blk_t;
  typedef struct { int id; logic [127:0] exp; } probe_t;
  blk_t qa[$], qb[$];
  probe_t probes[$];
  int errs = 0, checks = 0;
  bit done = 1'b0;
  always #5 clock = ~clock;
  word_block_packer #(.WSIZE(AW), .NWORDS(AN), .FIRST_MSB(1'b1)) u_a (
    .clock(clock), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .flush(a_flush), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count));
  word_block_packer #(.WSIZE(BW), .NWORDS(BN), .FIRST_MSB(1'b0)) u_b (
    .clock(clock), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush(b_flush), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count));
  function automatic logic [127:0] pval(input int id);
    case (id)
      0: return 128'(a_in_ready);
      1: return 128'(a_out_valid);
      2: return 128'(a_out_data);
      3: return 128'(a_out_count);
      4: return 128'(b_out_valid);
      5: return 128'(b_out_data);
      default: return 128'(b_out_count);
    endcase
  endfunction
  function automatic string pname(input int id);
    case (id)
      0: return "a_in_ready";
      1: return "a_out_valid";
      2: return "a_out_data";
      3: return "a_out_count";
      4: return "b_out_valid";
      5: return "b_out_data";
      default: return "b_out_count";
    endcase
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    probe_t p;
    blk_t e;
    while (probes.size() > 0) begin
      p = probes.pop_front();
      chk(pname(p.id), pval(p.id), p.exp);
    end
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_block", 128'(a_out_data), 128'hx);
      else begin
        e = qa.pop_front();
        chk("a_block_data", 128'(a_out_data), e.data);
        chk("a_block_count", 128'(a_out_count), 128'(e.count));
      end
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_block", 128'(b_out_data), 128'hx);
      else begin
        e = qb.pop_front();
        chk("b_block_data", 128'(b_out_data), e.data);
        chk("b_block_count", 128'(b_out_count), 128'(e.count));
      end
    end
    if (done) begin
      chk("a_blocks_missing", 128'(qa.size()), 128'd0);
      chk("b_blocks_missing", 128'(qb.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic probe(input int id, input logic [127:0] e);
    probes.push_back('{id, e});
  endtask
  task automatic push_a(input logic [127:0] d, input int c);
    qa.push_back('{d, c});
  endtask
  task automatic push_b(input logic [127:0] d, input int c);
    qb.push_back('{d, c});
  endtask
  task automatic put_a(input logic [31:0] w);
    bit ok;
    int n = 0;
    a_in_valid = 1'b1;
    a_in_data = w;
    do begin
      @(negedge clock);
      ok = a_in_ready;
      cyc();
      n++;
      if (!ok && n > 50) begin
        $display("FAIL put_a: word %h never accepted", w);
        $fatal(1);
      end
    end while (!ok);
    a_in_valid = 1'b0;
  endtask
  task automatic put_b(input logic [7:0] w);
    bit ok;
    int n = 0;
    b_in_valid = 1'b1;
    b_in_data = w;
    do begin
      @(negedge clock);
      ok = b_in_ready;
      cyc();
      n++;
      if (!ok && n > 50) begin
        $display("FAIL put_b: word %h never accepted", w);
        $fatal(1);
      end
    end while (!ok);
    b_in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    logic [31:0] w0;
    logic [127:0] blk1, blk2;
    for (int i = 1; i <= 6; i++) probe(i, 128'd0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    put_a(32'h11111111);
    put_a(32'h22222222);
    put_a(32'h33333333);
    put_a(32'h44444444);
    push_a(128'h11111111_22222222_33333333_44444444, 4);
    probe(1, 128'd1);
    probe(2, 128'h11111111_22222222_33333333_44444444);
    probe(3, 128'd4);
    cyc();
    probe(1, 128'd0);
    cyc();
    for (int i = 0; i < 12; i++) begin
      a_in_valid = 1'b1;
      a_in_data = 32'hA0000000 + 32'(i);
      probe(0, 128'd1);
      probe(1, 128'(i == 4 || i == 8));
      if (i % 4 == 3) begin
        w0 = 32'hA0000000 + 32'(i - 3);
        push_a({w0, w0 + 32'd1, w0 + 32'd2, w0 + 32'd3}, 4);
      end
      cyc();
    end
    a_in_valid = 1'b0;
    probe(1, 128'd1);
    cyc();
    probe(1, 128'd0);
    cyc();
    a_out_ready = 1'b0;
    for (int i = 0; i < 7; i++) put_a(32'hB0000000 + 32'(i));
    blk1 = {32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003};
    blk2 = {32'hB0000004, 32'hB0000005, 32'hB0000006, 32'hB0000007};
    push_a(blk1, 4);
    a_in_valid = 1'b1;
    a_in_data = 32'hB0000007;
    repeat (2) begin
      probe(0, 128'd0);
      probe(1, 128'd1);
      probe(2, blk1);
      probe(3, 128'd4);
      cyc();
    end
    a_out_ready = 1'b1;
    probe(0, 128'd1);
    push_a(blk2, 4);
    cyc();
    a_in_valid = 1'b0;
    probe(1, 128'd1);
    probe(2, blk2);
    cyc();
    probe(1, 128'd0);
    cyc();
    put_b(8'hAB);
    put_b(8'hCD);
    push_b(128'hCDAB, 2);
    probe(4, 128'd1);
    probe(5, 128'hCDAB);
    probe(6, 128'd2);
    cyc();
    put_b(8'h12);
    put_b(8'h34);
    push_b(128'h3412, 2);
    cyc();
    probe(4, 128'd0);
    cyc();
    put_a(32'hC0000001);
    put_a(32'hC0000002);
    reset = 1'b1;
    probe(1, 128'd0);
    probe(2, 128'd0);
    probe(3, 128'd0);
    probe(5, 128'd0);
    cyc();
    reset = 1'b0;
    cyc();
    put_a(32'hD0000001);
    put_a(32'hD0000002);
    put_a(32'hD0000003);
    put_a(32'hD0000004);
    push_a(128'hD0000001_D0000002_D0000003_D0000004, 4);
    probe(2, 128'hD0000001_D0000002_D0000003_D0000004);
    cyc();
    cyc();
`ifdef WORD_BLOCK_PACKER_FLUSH_EN
    put_a(32'hA);
    put_a(32'hB);
    put_a(32'hC);
    a_flush = 1'b1;
    push_a(128'h0000000A_0000000B_0000000C_00000000, 3);
    cyc();
    a_flush = 1'b0;
    probe(0, 128'd0);
    probe(1, 128'd0);
    cyc();
    probe(1, 128'd1);
    probe(2, 128'h0000000A_0000000B_0000000C_00000000);
    probe(3, 128'd3);
    cyc();
    a_flush = 1'b1;
    cyc();
    a_flush = 1'b0;
    probe(0, 128'd1);
    probe(1, 128'd0);
    cyc();
    probe(1, 128'd0);
    cyc();
    put_a(32'h1);
    put_a(32'h2);
    put_a(32'h3);
    a_in_valid = 1'b1;
    a_in_data = 32'h4;
    a_flush = 1'b1;
    push_a(128'h00000001_00000002_00000003_00000004, 4);
    cyc();
    a_in_valid = 1'b0;
    a_flush = 1'b0;
    probe(0, 128'd1);
    probe(1, 128'd1);
    probe(3, 128'd4);
    cyc();
    probe(0, 128'd1);
    probe(1, 128'd0);
    cyc();
    put_a(32'h5);
    put_a(32'h6);
    a_in_valid = 1'b1;
    a_in_data = 32'h7;
    a_flush = 1'b1;
    push_a(128'h00000005_00000006_00000007_00000000, 3);
    cyc();
    a_in_valid = 1'b0;
    a_flush = 1'b0;
    probe(0, 128'd0);
    cyc();
    probe(1, 128'd1);
    probe(3, 128'd3);
    cyc();
    cyc();
`else
    put_a(32'hA);
    put_a(32'hB);
    put_a(32'hC);
    a_flush = 1'b1;
    cyc();
    a_flush = 1'b0;
    probe(0, 128'd1);
    probe(1, 128'd0);
    put_a(32'hD);
    push_a(128'h0000000A_0000000B_0000000C_0000000D, 4);
    probe(3, 128'd4);
    cyc();
    cyc();
`endif
    for (int n = 0; n < 20 && (qa.size() > 0 || qb.size() > 0 || probes.size() > 0); n++) cyc();
    done = 1'b1;
  end
endmodule
